fast_pipe_arbiter: RTL and testbench
====================================

Name: fast_pipe_arbiter

Overview:
- Packet-granular weighted round-robin arbiter that shares the single FAST pipeline ingress between the TX-side and RX-side 256-bit AXI-Stream sources inside the port module.
- Forwards whole packets only, never interleaving beats of different packets.
- Tags each beat with its source.
- Maintains per-source packet counters for the control plane.

Parameters:
- DATA_W, 256, tdata width.
- KEEP_W, 32, tkeep width (DATA_W/8).
- USER_W, 128, tuser width (FAST metadata).
- WEIGHT_W, 4, width of weight configuration and credit counter.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_axis_tdata_int  in  DATA_W  TX source data.
- tx_axis_tkeep_int  in  KEEP_W  TX byte enables.
- tx_axis_tvalid_int  in  1  TX valid.
- tx_axis_tlast_int  in  1  TX end of packet.
- tx_axis_tuser_int  in  USER_W  TX metadata.
- tx_tready_int  out  1  TX ready.
- rx_axis_tdata_int  in  DATA_W  RX source data.
- rx_axis_tkeep_int  in  KEEP_W  RX byte enables.
- rx_axis_tvalid_int  in  1  RX valid.
- rx_axis_tlast_int  in  1  RX end of packet.
- rx_axis_tuser_int  in  USER_W  RX metadata.
- rx_tready_int  out  1  RX ready.
- pipe_axis_tdata  out  DATA_W  to pipeline.
- pipe_axis_tkeep  out  KEEP_W  to pipeline.
- pipe_axis_tvalid  out  1  to pipeline.
- pipe_axis_tlast  out  1  to pipeline.
- pipe_axis_tuser  out  USER_W  to pipeline.
- pipe_axis_tsrc  out  1  source tag: 0=TX, 1=RX.
- pipe_axis_tready  in  1  pipeline ready.
- cfg_tx_weight  in  WEIGHT_W  packets per TX turn.
- cfg_rx_weight  in  WEIGHT_W  packets per RX turn.
- stat_tx_pkts  out  CNT_W  TX packets forwarded.
- stat_rx_pkts  out  CNT_W  RX packets forwarded.
- busy  out  1  packet in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, ptr=0 (TX), credit=max(cfg_tx_weight,1) sampled at reset release.
  - All readies, pipe_axis_tvalid, busy and stats are 0.
- State machine: IDLE, GNT_TX, GNT_RX (registered).
- Datapath mux (combinational):
  - In GNT_x: pipe_axis_tdata/tkeep/tlast/tuser/tvalid = source x fields. pipe_axis_tsrc = x.
  - In GNT_x: x_tready = pipe_axis_tready. The other ready is 0.
  - In IDLE: all readies 0, pipe_axis_tvalid=0, other outputs 0.
  - Ready never depends combinationally on any input tvalid.
- busy = (state != IDLE).
- Arbitration function A (evaluated on source valids):
  - If valid[ptr]: grant ptr.
  - Else if valid[~ptr]: grant ~ptr; ptr←~ptr; credit←max(weight[~ptr],1).
  - Else: no grant.
- IDLE: if A grants, go to GNT_x next cycle. First beat is accepted at the earliest 1 cycle after tvalid is first seen in IDLE.
- GNT_x, handshake with tlast=1 (packet end):
  - stat_x_pkts+1, wrapping at 2^CNT_W.
  - If x==ptr: credit-1. If the result is 0: ptr←~ptr, credit←max(weight[~ptr],1).
  - Next state = A evaluated with the updated ptr/credit, so back-to-back packets have no bubble. If no grant, go to IDLE.
- Weight values of 0 behave as 1. Weights are sampled only on credit reload; mid-turn changes take effect at the next reload.
- Beats are held in GNT_x until tlast is accepted, regardless of pipe_axis_tready stalls or source tvalid gaps.
- Packets are never interleaved.
- Single-beat packets (tlast on the first beat) are legal.
- Only one source active: that source is re-granted each packet with no penalty. Its credit exhausts and reloads transparently.
- Both sources valid continuously: grant pattern is cfg_tx_weight TX packets, then cfg_rx_weight RX packets, repeating.
- Reset asserted mid-packet: returns immediately to reset values. The downstream packet is truncated, which is acceptable; the pipeline recovers via its own reset.

Test Plan:
- Single TX packet, 3 beats, pipe_axis_tready=1, RX idle -> first beat on pipe 1 cycle after tvalid; tsrc=0 on all beats; tlast on beat 3; stat_tx_pkts=1; busy falls the cycle after tlast.
- Both sources saturated with 1-beat packets, weights TX=2, RX=1 -> tsrc sequence 0,0,1,0,0,1…; no idle cycle between packets; after 30 packets stat_tx_pkts=20, stat_rx_pkts=10.
- TX 4-beat packet in progress; RX asserts valid at beat 2; pipe_axis_tready toggles 1,0,1,0 -> RX tready stays 0 until TX tlast is accepted; tdata order intact; RX packet starts on the next cycle.
- Weights both 0, alternating 1-beat traffic from both sources -> strict alternation 0,1,0,1 (weight 0 treated as 1).
- Stats preset to 2^32-1 via forced traffic or force -> next packet wraps the counter to 0.
- rst_n deasserted for 1 cycle during beat 2 of a 3-beat RX packet -> readies, tvalid and busy drop immediately; stats return to 0; after release, a new TX packet is granted normally with ptr=TX.

Source files
------------

// File: rtl/fast_pipe_arbiter.sv
// fast_pipe_arbiter
// Shares the FAST pipeline ingress between the TX-side and RX-side AXI-Stream
// sources. Arbitration is packet-granular weighted round-robin: the source
// holding the pointer keeps the grant for a number of packets equal to its
// weight, then the turn passes to the other source. Beats from different
// packets are never interleaved. Every forwarded beat is tagged with its
// source, and a packet counter is kept for each source.
module fast_pipe_arbiter #(
    parameter int DATA_W   = 256,
    parameter int KEEP_W   = 32,
    parameter int USER_W   = 128,
    parameter int WEIGHT_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [DATA_W-1:0]   tx_axis_tdata_int,
    input  logic [KEEP_W-1:0]   tx_axis_tkeep_int,
    input  logic                tx_axis_tvalid_int,
    input  logic                tx_axis_tlast_int,
    input  logic [USER_W-1:0]   tx_axis_tuser_int,
    output logic                tx_tready_int,

    input  logic [DATA_W-1:0]   rx_axis_tdata_int,
    input  logic [KEEP_W-1:0]   rx_axis_tkeep_int,
    input  logic                rx_axis_tvalid_int,
    input  logic                rx_axis_tlast_int,
    input  logic [USER_W-1:0]   rx_axis_tuser_int,
    output logic                rx_tready_int,

    output logic [DATA_W-1:0]   pipe_axis_tdata,
    output logic [KEEP_W-1:0]   pipe_axis_tkeep,
    output logic                pipe_axis_tvalid,
    output logic                pipe_axis_tlast,
    output logic [USER_W-1:0]   pipe_axis_tuser,
    output logic                pipe_axis_tsrc,
    input  logic                pipe_axis_tready,

    input  logic [WEIGHT_W-1:0] cfg_tx_weight,
    input  logic [WEIGHT_W-1:0] cfg_rx_weight,

    output logic [CNT_W-1:0]    stat_tx_pkts,
    output logic [CNT_W-1:0]    stat_rx_pkts,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_TX = 2'd1,
        GNT_RX = 2'd2
    } state_t;

    // Result of one arbitration decision.
    typedef struct packed {
        logic                grant;
        logic                src;
        logic                ptr;
        logic [WEIGHT_W-1:0] credit;
    } arb_t;

    state_t              state;
    state_t              state_next;
    logic                ptr;          // source owning the current turn: 0=TX, 1=RX
    logic                ptr_next;
    logic [WEIGHT_W-1:0] credit;       // packets left in the current turn
    logic [WEIGHT_W-1:0] credit_next;
    logic                credit_init;  // high for the first cycle after reset release
    logic                in_pkt;       // at least one beat of the granted packet accepted
    logic                in_pkt_next;
    logic                tx_pkt_done;
    logic                rx_pkt_done;

    logic [1:0]          src_valid;
    logic [1:0]          src_last;
    logic                cur_src;
    logic                cur_valid;
    logic                cur_last;
    logic [WEIGHT_W-1:0] base_credit;
    logic                end_ptr;
    logic [WEIGHT_W-1:0] end_credit;
    arb_t                arb;

    // A weight of zero is treated as one packet per turn.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        if (w == '0) begin
            return WEIGHT_W'(1);
        end
        return w;
    endfunction

    // Grant the pointer source if it is valid, otherwise hand the turn to
    // the other source and load that source's weight as the new credit.
    function automatic arb_t arbitrate(input logic [1:0]          valid,
                                       input logic                p,
                                       input logic [WEIGHT_W-1:0] c,
                                       input logic [WEIGHT_W-1:0] w_tx,
                                       input logic [WEIGHT_W-1:0] w_rx);
        arb_t r;
        r.grant  = 1'b0;
        r.src    = p;
        r.ptr    = p;
        r.credit = c;
        if (valid[p]) begin
            r.grant = 1'b1;
        end else if (valid[~p]) begin
            r.grant  = 1'b1;
            r.src    = ~p;
            r.ptr    = ~p;
            r.credit = eff_weight(p ? w_tx : w_rx);
        end
        return r;
    endfunction

    assign src_valid = {rx_axis_tvalid_int, tx_axis_tvalid_int};
    assign src_last  = {rx_axis_tlast_int,  tx_axis_tlast_int};
    assign busy      = (state != IDLE);

    // Next-state, pointer and credit update; packet ends re-arbitrate in the
    // same cycle so consecutive packets flow without a bubble.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        in_pkt_next = in_pkt;
        tx_pkt_done = 1'b0;
        rx_pkt_done = 1'b0;
        cur_src     = (state == GNT_RX);
        cur_valid   = src_valid[cur_src];
        cur_last    = src_last[cur_src];
        // The TX weight is captured on the first cycle after reset release.
        base_credit = credit_init ? eff_weight(cfg_tx_weight) : credit;
        credit_next = base_credit;
        end_ptr     = ptr;
        end_credit  = base_credit;
        arb         = '0;

        case (state)
            IDLE: begin
                arb = arbitrate(src_valid, ptr, base_credit, cfg_tx_weight, cfg_rx_weight);
                if (arb.grant) begin
                    state_next  = arb.src ? GNT_RX : GNT_TX;
                    ptr_next    = arb.ptr;
                    credit_next = arb.credit;
                    in_pkt_next = 1'b0;
                end
            end

            GNT_TX, GNT_RX: begin
                if (cur_valid && pipe_axis_tready) begin
                    if (cur_last) begin
                        tx_pkt_done = ~cur_src;
                        rx_pkt_done = cur_src;
                        if (cur_src == ptr) begin
                            end_credit = base_credit - WEIGHT_W'(1);
                            if (end_credit == '0) begin
                                end_ptr    = ~ptr;
                                end_credit = eff_weight(ptr ? cfg_tx_weight : cfg_rx_weight);
                            end
                        end
                        arb = arbitrate(src_valid, end_ptr, end_credit,
                                        cfg_tx_weight, cfg_rx_weight);
                        state_next  = arb.grant ? (arb.src ? GNT_RX : GNT_TX) : IDLE;
                        ptr_next    = arb.ptr;
                        credit_next = arb.credit;
                        in_pkt_next = 1'b0;
                    end else begin
                        in_pkt_next = 1'b1;
                    end
                end else if (!in_pkt && !cur_valid) begin
                    // The re-grant at the previous packet end found no new
                    // packet from this source; release the ingress without
                    // spending any credit.
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration registers: grant FSM, round-robin pointer and turn credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            credit      <= '0;
            credit_init <= 1'b1;
            in_pkt      <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            credit      <= credit_next;
            credit_init <= 1'b0;
            in_pkt      <= in_pkt_next;
        end
    end

    // Per-source forwarded-packet counters, wrapping at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tx_pkts <= '0;
            stat_rx_pkts <= '0;
        end else begin
            if (tx_pkt_done) begin
                stat_tx_pkts <= stat_tx_pkts + CNT_W'(1);
            end
            if (rx_pkt_done) begin
                stat_rx_pkts <= stat_rx_pkts + CNT_W'(1);
            end
        end
    end

    // Datapath mux: the granted source drives the pipe and sees its ready.
    always_comb begin
        tx_tready_int    = 1'b0;
        rx_tready_int    = 1'b0;
        pipe_axis_tdata  = '0;
        pipe_axis_tkeep  = '0;
        pipe_axis_tvalid = 1'b0;
        pipe_axis_tlast  = 1'b0;
        pipe_axis_tuser  = '0;
        pipe_axis_tsrc   = 1'b0;
        case (state)
            GNT_TX: begin
                pipe_axis_tdata  = tx_axis_tdata_int;
                pipe_axis_tkeep  = tx_axis_tkeep_int;
                pipe_axis_tvalid = tx_axis_tvalid_int;
                pipe_axis_tlast  = tx_axis_tlast_int;
                pipe_axis_tuser  = tx_axis_tuser_int;
                pipe_axis_tsrc   = 1'b0;
                tx_tready_int    = pipe_axis_tready;
            end
            GNT_RX: begin
                pipe_axis_tdata  = rx_axis_tdata_int;
                pipe_axis_tkeep  = rx_axis_tkeep_int;
                pipe_axis_tvalid = rx_axis_tvalid_int;
                pipe_axis_tlast  = rx_axis_tlast_int;
                pipe_axis_tuser  = rx_axis_tuser_int;
                pipe_axis_tsrc   = 1'b1;
                rx_tready_int    = pipe_axis_tready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fast_pipe_arbiter.sv
// tb_fast_pipe_arbiter
// Scoreboard bench: each test pushes the beats it expects on the pipe, in
// the order the arbiter should forward them, and a monitor pops and compares
// on every pipe handshake. Counters are instantiated 8 bits wide so that the
// wrap-around can be reached with real traffic.
module tb_fast_pipe_arbiter;

    localparam int DATA_W   = 256;
    localparam int KEEP_W   = 32;
    localparam int USER_W   = 128;
    localparam int WEIGHT_W = 4;
    localparam int CNT_W    = 8;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;

    logic [DATA_W-1:0]   tx_tdata;
    logic [KEEP_W-1:0]   tx_tkeep;
    logic                tx_tvalid;
    logic                tx_tlast;
    logic [USER_W-1:0]   tx_tuser;
    logic                tx_tready;
    logic [DATA_W-1:0]   rx_tdata;
    logic [KEEP_W-1:0]   rx_tkeep;
    logic                rx_tvalid;
    logic                rx_tlast;
    logic [USER_W-1:0]   rx_tuser;
    logic                rx_tready;
    logic [DATA_W-1:0]   pipe_tdata;
    logic [KEEP_W-1:0]   pipe_tkeep;
    logic                pipe_tvalid;
    logic                pipe_tlast;
    logic [USER_W-1:0]   pipe_tuser;
    logic                pipe_tsrc;
    logic                pipe_tready;
    logic [WEIGHT_W-1:0] cfg_tx_weight;
    logic [WEIGHT_W-1:0] cfg_rx_weight;
    logic [CNT_W-1:0]    stat_tx;
    logic [CNT_W-1:0]    stat_rx;
    logic                busy;

    always #5 clk = ~clk;

    fast_pipe_arbiter #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W),
        .WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_axis_tdata_int(tx_tdata),
        .tx_axis_tkeep_int(tx_tkeep),
        .tx_axis_tvalid_int(tx_tvalid),
        .tx_axis_tlast_int(tx_tlast),
        .tx_axis_tuser_int(tx_tuser),
        .tx_tready_int(tx_tready),
        .rx_axis_tdata_int(rx_tdata),
        .rx_axis_tkeep_int(rx_tkeep),
        .rx_axis_tvalid_int(rx_tvalid),
        .rx_axis_tlast_int(rx_tlast),
        .rx_axis_tuser_int(rx_tuser),
        .rx_tready_int(rx_tready),
        .pipe_axis_tdata(pipe_tdata),
        .pipe_axis_tkeep(pipe_tkeep),
        .pipe_axis_tvalid(pipe_tvalid),
        .pipe_axis_tlast(pipe_tlast),
        .pipe_axis_tuser(pipe_tuser),
        .pipe_axis_tsrc(pipe_tsrc),
        .pipe_axis_tready(pipe_tready),
        .cfg_tx_weight(cfg_tx_weight),
        .cfg_rx_weight(cfg_rx_weight),
        .stat_tx_pkts(stat_tx),
        .stat_rx_pkts(stat_rx),
        .busy(busy)
    );

    typedef struct {
        logic              src;
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cycle    = 0;
    int    hs_count = 0;
    int    first_hs = 0;
    int    last_hs  = 0;

    // Beat payloads encode source, packet number and beat number.
    function automatic logic [DATA_W-1:0] mk_data(input bit src, input int pkt, input int beat);
        logic [DATA_W-1:0] d;
        logic [31:0]       tag;
        tag = (src ? 32'h2000_0000 : 32'h1000_0000) + 32'(pkt << 8) + 32'(beat);
        d = '0;
        d[31:0]           = tag;
        d[DATA_W-1 -: 32] = ~tag;
        return d;
    endfunction

    function automatic logic [USER_W-1:0] mk_user(input bit src, input int pkt, input int beat);
        logic [DATA_W-1:0] d;
        logic [USER_W-1:0] u;
        d = mk_data(src, pkt, beat);
        u = '0;
        u[63:0] = {~d[31:0], d[31:0]};
        return u;
    endfunction

    function automatic logic [KEEP_W-1:0] mk_keep(input bit last);
        return last ? KEEP_W'(32'h0000_FFFF) : '1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input bit src, input int pkt, input int beat, input bit last);
        beat_t b;
        b.src  = src;
        b.data = mk_data(src, pkt, beat);
        b.keep = mk_keep(last);
        b.user = mk_user(src, pkt, beat);
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input bit src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            push_beat(src, pkt, b, b == nbeats - 1);
        end
    endtask

    task automatic drive(input bit src, input bit v, input logic [DATA_W-1:0] d,
                         input logic [KEEP_W-1:0] k, input logic [USER_W-1:0] u, input bit l);
        if (src) begin
            rx_tvalid = v; rx_tdata = d; rx_tkeep = k; rx_tuser = u; rx_tlast = l;
        end else begin
            tx_tvalid = v; tx_tdata = d; tx_tkeep = k; tx_tuser = u; tx_tlast = l;
        end
    endtask

    // Waits for the source's ready, then returns 1 time unit after the
    // clock edge that completes the handshake.
    task automatic wait_accept(input bit src);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rst_n && (src ? rx_tready : tx_tready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout src=%0d: got no ready in 400 cycles, required ready", src);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bit src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            drive(src, 1'b1, mk_data(src, pkt, b), mk_keep(b == nbeats - 1),
                  mk_user(src, pkt, b), b == nbeats - 1);
            wait_accept(src);
        end
        drive(src, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset(input logic [WEIGHT_W-1:0] tw, input logic [WEIGHT_W-1:0] rw);
        rst_n         = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        pipe_tready   = 1'b1;
        cfg_tx_weight = tw;
        cfg_rx_weight = rw;
        exp_q.delete();
        hs_count      = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_tready", 64'(tx_tready), 64'(0));
        chk("rst_rx_tready", 64'(rx_tready), 64'(0));
        chk("rst_pipe_tvalid", 64'(pipe_tvalid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stat_tx", 64'(stat_tx), 64'(0));
        chk("rst_stat_rx", 64'(stat_rx), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Cycle counter used to time handshakes.
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Scoreboard monitor: compares every beat the pipe accepts.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && pipe_tvalid && pipe_tready) begin
                hs_count++;
                if (hs_count == 1) first_hs = cycle;
                last_hs = cycle;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat src=%0d data=%0h, required no beat",
                             pipe_tsrc, pipe_tdata[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (pipe_tsrc !== e.src || pipe_tdata !== e.data || pipe_tkeep !== e.keep ||
                        pipe_tuser !== e.user || pipe_tlast !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_beat: got src=%0d last=%0d data=%0h keep=%0h user=%0h, required src=%0d last=%0d data=%0h keep=%0h user=%0h",
                                 pipe_tsrc, pipe_tlast, pipe_tdata[31:0], pipe_tkeep, pipe_tuser[63:0],
                                 e.src, e.last, e.data[31:0], e.keep, e.user[63:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tx_done;
        bit t3_done;
        int rx_bad;
        int tp;
        int rp;

        pipe_tready   = 1'b1;
        cfg_tx_weight = '0;
        cfg_rx_weight = '0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        #1;

        // Single 3-beat TX packet, RX idle.
        do_reset(4'd1, 4'd1);
        push_pkt(1'b0, 0, 3);
        fork
            send_pkt(1'b0, 0, 3);
            begin
                @(negedge clk);
                chk("t1_idle_first_cycle", 64'(pipe_tvalid), 64'(0));
                @(negedge clk);
                chk("t1_first_beat_valid_src", 64'({pipe_tvalid, pipe_tsrc}), 64'(2'b10));
            end
        join
        chk("t1_stat_tx", 64'(stat_tx), 64'(1));
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_fall", 64'(busy), 64'(0));
        drain("t1_drain");

        // Both sources saturated with 1-beat packets, weights TX=2 RX=1.
        do_reset(4'd2, 4'd1);
        tp = 0;
        rp = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 != 2) begin
                push_pkt(1'b0, tp, 1);
                tp++;
            end else begin
                push_pkt(1'b1, rp, 1);
                rp++;
            end
        end
        fork
            begin
                for (int k = 0; k < 20; k++) send_pkt(1'b0, k, 1);
            end
            begin
                for (int k = 0; k < 10; k++) send_pkt(1'b1, k, 1);
            end
        join
        drain("t2_drain");
        chk("t2_stat_tx", 64'(stat_tx), 64'(20));
        chk("t2_stat_rx", 64'(stat_rx), 64'(10));
        chk("t2_beats", 64'(hs_count), 64'(30));
        chk("t2_no_bubble_span", 64'(last_hs - first_hs), 64'(29));

        // TX 4-beat packet under toggling ready while RX requests mid-packet.
        do_reset(4'd1, 4'd1);
        push_pkt(1'b0, 0, 4);
        push_pkt(1'b1, 0, 2);
        tx_done = 1'b0;
        t3_done = 1'b0;
        rx_bad  = 0;
        fork
            begin
                fork
                    begin
                        send_pkt(1'b0, 0, 4);
                        tx_done = 1'b1;
                        @(negedge clk);
                        chk("t3_rx_next_cycle", 64'({pipe_tvalid, pipe_tsrc, busy}), 64'(3'b111));
                    end
                    begin
                        repeat (2) @(posedge clk);
                        #1;
                        send_pkt(1'b1, 0, 2);
                    end
                    begin
                        for (int i = 0; i < 200 && !tx_done; i++) begin
                            @(negedge clk);
                            if (rx_tready && !tx_done) rx_bad++;
                        end
                    end
                join
                t3_done = 1'b1;
            end
            begin
                while (!t3_done) begin
                    @(posedge clk);
                    #1;
                    pipe_tready = ~pipe_tready;
                end
                pipe_tready = 1'b1;
            end
        join
        chk("t3_rx_ready_held_low", 64'(rx_bad), 64'(0));
        drain("t3_drain");
        chk("t3_stat_tx", 64'(stat_tx), 64'(1));
        chk("t3_stat_rx", 64'(stat_rx), 64'(1));

        // Both weights zero: strict alternation starting with TX.
        do_reset(4'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            push_pkt(i[0], i / 2, 1);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send_pkt(1'b0, k, 1);
            end
            begin
                for (int k = 0; k < 3; k++) send_pkt(1'b1, k, 1);
            end
        join
        drain("t4_drain");
        chk("t4_stat_tx", 64'(stat_tx), 64'(3));
        chk("t4_stat_rx", 64'(stat_rx), 64'(3));

        // Counter wrap-around at full scale.
        do_reset(4'd1, 4'd1);
        for (int k = 0; k < 255; k++) push_pkt(1'b0, k, 1);
        for (int k = 0; k < 255; k++) send_pkt(1'b0, k, 1);
        chk("t5_stat_tx_full", 64'(stat_tx), 64'(255));
        push_pkt(1'b0, 255, 1);
        send_pkt(1'b0, 255, 1);
        chk("t5_stat_tx_wrap", 64'(stat_tx), 64'(0));
        chk("t5_stat_rx", 64'(stat_rx), 64'(0));
        drain("t5_drain");

        // Reset asserted during beat 2 of a 3-beat RX packet.
        do_reset(4'd1, 4'd1);
        push_pkt(1'b0, 0, 1);
        send_pkt(1'b0, 0, 1);
        chk("t6_pre_stat_tx", 64'(stat_tx), 64'(1));
        push_beat(1'b1, 0, 0, 1'b0);
        drive(1'b1, 1'b1, mk_data(1'b1, 0, 0), mk_keep(1'b0), mk_user(1'b1, 0, 0), 1'b0);
        wait_accept(1'b1);
        drive(1'b1, 1'b1, mk_data(1'b1, 0, 1), mk_keep(1'b0), mk_user(1'b1, 0, 1), 1'b0);
        #2;
        chk("t6_mid_pkt", 64'({rx_tready, pipe_tvalid, busy}), 64'(3'b111));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_readies", 64'({tx_tready, rx_tready}), 64'(0));
        chk("t6_rst_tvalid", 64'(pipe_tvalid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_stat_tx", 64'(stat_tx), 64'(0));
        chk("t6_rst_stat_rx", 64'(stat_rx), 64'(0));
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain("t6_drain_abort");
        push_pkt(1'b0, 1, 1);
        push_pkt(1'b1, 1, 1);
        fork
            send_pkt(1'b0, 1, 1);
            send_pkt(1'b1, 1, 1);
        join
        drain("t6_drain");
        chk("t6_post_stat_tx", 64'(stat_tx), 64'(1));
        chk("t6_post_stat_rx", 64'(stat_rx), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
